// File: rtl/uart_text_writer_if.sv
// Bus between the UART byte source and the text-RAM writer: received bytes in,
// RAM write port and cursor/status out.
interface uart_text_writer_if #(
  parameter int unsigned COL_W = 7,
  parameter int unsigned ROW_W = 8
);
  logic                     rx_valid;
  logic [7:0]               rx_byte;
  logic                     ovr_clr;
  logic                     wr_en;
  logic [ROW_W+COL_W-1:0]   wr_addr;
  logic [7:0]               wr_data;
  logic [COL_W-1:0]         cursor_col;
  logic [ROW_W-1:0]         cursor_row;
  logic                     busy;
  logic                     overrun;

  modport master (
    output rx_valid, rx_byte, ovr_clr,
    input  wr_en, wr_addr, wr_data, cursor_col, cursor_row, busy, overrun
  );

  modport slave (
    input  rx_valid, rx_byte, ovr_clr,
    output wr_en, wr_addr, wr_data, cursor_col, cursor_row, busy, overrun
  );
endinterface

// File: rtl/uart_text_writer.sv
// Terminal front end: turns a UART byte stream into text-RAM writes with cursor
// movement, backspace, clear screen and ESC col,row positioning.
module uart_text_writer #(
  parameter int unsigned COLS  = 120,
  parameter int unsigned ROWS  = 150,
  parameter int unsigned COL_W = 7,
  parameter int unsigned ROW_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  uart_text_writer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StEscCol, StEscRow, StClear} state_e;

  localparam logic [COL_W-1:0] LastCol = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LastRow = ROW_W'(ROWS - 1);
  localparam logic [7:0]       Space   = 8'h20;

  state_e                 state_q, state_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [COL_W-1:0]       esc_col_q, esc_col_d;
  logic [COL_W-1:0]       clr_col_q, clr_col_d;
  logic [ROW_W-1:0]       clr_row_q, clr_row_d;
  logic                   clr_last_q, clr_last_d;
  logic                   wr_en_q, wr_en_d;
  logic [ROW_W+COL_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]             wr_data_q, wr_data_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;

  function automatic logic [ROW_W-1:0] row_inc(input logic [ROW_W-1:0] r);
    return (r == LastRow) ? '0 : r + ROW_W'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    esc_col_d  = esc_col_q;
    clr_col_d  = clr_col_q;
    clr_row_d  = clr_row_q;
    clr_last_d = clr_last_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    overrun_d  = overrun_q;

    // A drop beats a simultaneous clear request.
    if (bus.rx_valid && busy_q) begin
      overrun_d = 1'b1;
    end else if (bus.ovr_clr) begin
      overrun_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (bus.rx_valid) begin
          if (bus.rx_byte >= 8'h20 && bus.rx_byte <= 8'h7e) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {row_q, col_q};
            wr_data_d = bus.rx_byte;
            if (col_q == LastCol) begin
              col_d = '0;
              row_d = row_inc(row_q);
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else begin
            case (bus.rx_byte)
              8'h0d: col_d = '0;
              8'h0a: row_d = row_inc(row_q);
              8'h08: begin
                if (col_q != '0) begin
                  col_d     = col_q - COL_W'(1);
                  wr_en_d   = 1'b1;
                  wr_addr_d = {row_q, col_q - COL_W'(1)};
                  wr_data_d = Space;
                end
              end
              8'h0c: begin
                // First clear write goes out together with busy; the sweep
                // continues from (0,1).
                state_d    = StClear;
                busy_d     = 1'b1;
                wr_en_d    = 1'b1;
                wr_addr_d  = '0;
                wr_data_d  = Space;
                clr_row_d  = '0;
                clr_col_d  = COL_W'(1);
                clr_last_d = 1'b0;
              end
              8'h1b: state_d = StEscCol;
              default: ;
            endcase
          end
        end
      end

      StEscCol: begin
        if (bus.rx_valid) begin
          esc_col_d = (32'(bus.rx_byte) >= COLS) ? LastCol : COL_W'(bus.rx_byte);
          state_d   = StEscRow;
        end
      end

      StEscRow: begin
        if (bus.rx_valid) begin
          row_d   = (32'(bus.rx_byte) >= ROWS) ? LastRow : ROW_W'(bus.rx_byte);
          col_d   = esc_col_q;
          state_d = StIdle;
        end
      end

      StClear: begin
        if (clr_last_q) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          col_d   = '0;
          row_d   = '0;
        end else begin
          wr_en_d    = 1'b1;
          wr_addr_d  = {clr_row_q, clr_col_q};
          wr_data_d  = Space;
          clr_last_d = (clr_row_q == LastRow) && (clr_col_q == LastCol);
          if (clr_col_q == LastCol) begin
            clr_col_d = '0;
            clr_row_d = clr_row_q + ROW_W'(1);
          end else begin
            clr_col_d = clr_col_q + COL_W'(1);
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      col_q      <= '0;
      row_q      <= '0;
      esc_col_q  <= '0;
      clr_col_q  <= '0;
      clr_row_q  <= '0;
      clr_last_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      esc_col_q  <= esc_col_d;
      clr_col_q  <= clr_col_d;
      clr_row_q  <= clr_row_d;
      clr_last_q <= clr_last_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.cursor_col = col_q;
  assign bus.cursor_row = row_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_text_writer.sv
// Self-checking bench for uart_text_writer: directed vector table, random bytes
// against a terminal model, clear-screen sweep and async reset.
module tb_uart_text_writer;
  localparam int COLS  = 120;
  localparam int ROWS  = 150;
  localparam int COL_W = 7;
  localparam int ROW_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_text_writer_if #(.COL_W(COL_W), .ROW_W(ROW_W)) bus ();

  uart_text_writer #(.COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Terminal model: cursor, escape progress, pending escape column.
  int m_col = 0, m_row = 0, m_mode = 0, m_esc = 0;

  typedef struct {
    logic [7:0] b;
    bit         we;
    int         row;
    int         col;
    logic [7:0] d;
    int         ccol;
    int         crow;
  } vec_t;

  vec_t vecs[$];
  bit   seen[0:32767];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int addr_of(input int row, input int col);
    return row * (1 << COL_W) + col;
  endfunction

  task automatic model(input logic [7:0] b, output bit we, output int addr, output logic [7:0] d);
    we = 0; addr = 0; d = 0;
    if (m_mode == 1) begin
      m_esc  = (b >= COLS) ? COLS - 1 : int'(b);
      m_mode = 2;
    end else if (m_mode == 2) begin
      m_row  = (b >= ROWS) ? ROWS - 1 : int'(b);
      m_col  = m_esc;
      m_mode = 0;
    end else if (b >= 8'h20 && b <= 8'h7e) begin
      we = 1; addr = addr_of(m_row, m_col); d = b;
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
      end
    end else if (b == 8'h0d) begin
      m_col = 0;
    end else if (b == 8'h0a) begin
      m_row = (m_row + 1) % ROWS;
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        we = 1; addr = addr_of(m_row, m_col); d = 8'h20;
      end
    end else if (b == 8'h1b) begin
      m_mode = 1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_check(input logic [7:0] b, input bit we, input int addr,
                            input logic [7:0] d, input int ccol, input int crow,
                            input string tag);
    send(b);
    check({tag, " wr_en"}, bus.wr_en, we);
    if (we) begin
      check({tag, " wr_addr"}, bus.wr_addr, addr);
      check({tag, " wr_data"}, bus.wr_data, d);
    end
    check({tag, " cursor_col"}, bus.cursor_col, ccol);
    check({tag, " cursor_row"}, bus.cursor_row, crow);
    @(posedge clk);
    #1;
    check({tag, " wr_en pulse"}, bus.wr_en, 0);
  endtask

  initial begin
    bit         we;
    int         a;
    logic [7:0] d;
    logic [7:0] b;
    int         cnt, nwr, bad;

    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    bus.ovr_clr  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset wr_en", bus.wr_en, 0);
    check("reset wr_addr", bus.wr_addr, 0);
    check("reset wr_data", bus.wr_data, 0);
    check("reset cursor_col", bus.cursor_col, 0);
    check("reset cursor_row", bus.cursor_row, 0);
    check("reset busy", bus.busy, 0);
    check("reset overrun", bus.overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // {byte, write?, row, col, data, cursor col, cursor row}
    vecs.push_back('{8'h41, 1, 0, 0, 8'h41, 1, 0});
    vecs.push_back('{8'h68, 1, 0, 1, 8'h68, 2, 0});
    vecs.push_back('{8'h6f, 1, 0, 2, 8'h6f, 3, 0});
    vecs.push_back('{8'h6a, 1, 0, 3, 8'h6a, 4, 0});
    vecs.push_back('{8'h08, 1, 0, 3, 8'h20, 3, 0});
    vecs.push_back('{8'h08, 1, 0, 2, 8'h20, 2, 0});
    vecs.push_back('{8'h0d, 0, 0, 0, 8'h00, 0, 0});
    vecs.push_back('{8'h08, 0, 0, 0, 8'h00, 0, 0});
    vecs.push_back('{8'h00, 0, 0, 0, 8'h00, 0, 0});
    vecs.push_back('{8'h7f, 0, 0, 0, 8'h00, 0, 0});
    vecs.push_back('{8'hff, 0, 0, 0, 8'h00, 0, 0});
    vecs.push_back('{8'h1b, 0, 0, 0, 8'h00, 0, 0});
    vecs.push_back('{8'd119, 0, 0, 0, 8'h00, 0, 0});
    vecs.push_back('{8'd5, 0, 0, 0, 8'h00, 119, 5});
    vecs.push_back('{8'h58, 1, 5, 119, 8'h58, 0, 6});
    vecs.push_back('{8'h59, 1, 6, 0, 8'h59, 1, 6});
    vecs.push_back('{8'h1b, 0, 0, 0, 8'h00, 1, 6});
    vecs.push_back('{8'd200, 0, 0, 0, 8'h00, 1, 6});
    vecs.push_back('{8'd200, 0, 0, 0, 8'h00, 119, 149});
    vecs.push_back('{8'h0a, 0, 0, 0, 8'h00, 119, 0});
    vecs.push_back('{8'h1b, 0, 0, 0, 8'h00, 119, 0});
    vecs.push_back('{8'd50, 0, 0, 0, 8'h00, 119, 0});
    vecs.push_back('{8'd3, 0, 0, 0, 8'h00, 50, 3});
    vecs.push_back('{8'h0d, 0, 0, 0, 8'h00, 0, 3});
    vecs.push_back('{8'h1b, 0, 0, 0, 8'h00, 0, 3});
    vecs.push_back('{8'h0c, 0, 0, 0, 8'h00, 0, 3});
    vecs.push_back('{8'h0d, 0, 0, 0, 8'h00, 12, 13});
    vecs.push_back('{8'h21, 1, 13, 12, 8'h21, 13, 13});

    foreach (vecs[i]) begin
      model(vecs[i].b, we, a, d);
      send_check(vecs[i].b, vecs[i].we, addr_of(vecs[i].row, vecs[i].col), vecs[i].d,
                 vecs[i].ccol, vecs[i].crow, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       b = 8'h08;
          1:       b = 8'h0a;
          2:       b = 8'h0d;
          default: b = 8'h1b;
        endcase
      end else begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h0c) b = 8'h41;
      end
      model(b, we, a, d);
      send_check(b, we, a, d, m_col, m_row, $sformatf("rand%0d", i));
    end

    for (int i = 0; i < 3 && m_mode != 0; i++) begin
      model(8'h41, we, a, d);
      send_check(8'h41, we, a, d, m_col, m_row, "flush");
    end

    // Clear screen with drops and overrun handling during the sweep.
    for (int i = 0; i < 32768; i++) seen[i] = 1'b0;
    send(8'h0c);
    cnt = 0; nwr = 0; bad = 0;
    while (bus.busy === 1'b1 && cnt < 20000) begin
      if (bus.wr_en === 1'b1) begin
        if (bus.wr_data !== 8'h20 || int'(bus.wr_addr[COL_W-1:0]) >= COLS ||
            int'(bus.wr_addr[ROW_W+COL_W-1:COL_W]) >= ROWS || seen[bus.wr_addr])
          bad++;
        else
          seen[bus.wr_addr] = 1'b1;
        nwr++;
      end
      case (cnt)
        100: begin bus.rx_valid = 1'b1; bus.rx_byte = 8'h41; end
        101: begin bus.rx_valid = 1'b0; check("clear drop overrun", bus.overrun, 1); end
        200: bus.ovr_clr = 1'b1;
        201: begin bus.ovr_clr = 1'b0; check("ovr_clr", bus.overrun, 0); end
        300: begin bus.rx_valid = 1'b1; bus.rx_byte = 8'h42; bus.ovr_clr = 1'b1; end
        301: begin
          bus.rx_valid = 1'b0; bus.ovr_clr = 1'b0;
          check("drop beats ovr_clr", bus.overrun, 1);
        end
        default: ;
      endcase
      cnt++;
      @(posedge clk);
      #1;
    end
    check("clear busy cycles", cnt, 18000);
    check("clear write count", nwr, 18000);
    check("clear bad writes", bad, 0);
    check("clear wr_en after", bus.wr_en, 0);
    check("clear cursor_col", bus.cursor_col, 0);
    check("clear cursor_row", bus.cursor_row, 0);
    check("overrun sticky", bus.overrun, 1);
    m_col = 0; m_row = 0; m_mode = 0;
    @(negedge clk);
    bus.ovr_clr = 1'b1;
    @(negedge clk);
    bus.ovr_clr = 1'b0;
    check("overrun cleared", bus.overrun, 0);
    model(8'h51, we, a, d);
    send_check(8'h51, we, a, d, m_col, m_row, "post-clear");

    // Asynchronous reset in the middle of a clear.
    send(8'h0c);
    repeat (50) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async wr_en", bus.wr_en, 0);
    check("async wr_addr", bus.wr_addr, 0);
    check("async busy", bus.busy, 0);
    check("async cursor_col", bus.cursor_col, 0);
    check("async cursor_row", bus.cursor_row, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_col = 0; m_row = 0; m_mode = 0;
    send_check(8'h5a, 1, 0, 8'h5a, 1, 0, "after reset Z");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
